// File: rtl/instr_fetch.sv
// instr_fetch: PC/fetch sequencer feeding a valid/ready instruction register.
// Define FETCH_PREFETCH_EN to overlap the next read with the S_HOLD handshake.
module instr_fetch #(
  parameter int          MEM_WORDS = 16384,
  parameter logic [15:0] RESET_PC  = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        jump,
  input  logic [15:0] jump_addr,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instr,
  output logic [3:0]  opcode,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] pc
);
  localparam logic [15:0] MASK = 16'(MEM_WORDS - 1);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_HOLD} state_t;
`ifdef FETCH_PREFETCH_EN
  localparam logic   PREFETCH = 1'b1;
  localparam state_t HS_NEXT  = S_DATA;
`else
  localparam logic   PREFETCH = 1'b0;
  localparam state_t HS_NEXT  = S_REQ;
`endif
  state_t state, state_nx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_IDLE;
    else state <= state_nx;
  // jump overrides everything; a handshake coinciding with it still completes
  always_comb begin
    state_nx = jump                ? (run ? S_REQ : S_IDLE) :
               state == S_IDLE     ? (run ? S_REQ : S_IDLE) :
               state == S_REQ      ? S_DATA :
               state == S_DATA     ? S_HOLD :
               !instr_ready        ? S_HOLD :
               run                 ? HS_NEXT : S_IDLE;
  end
  always_comb begin
    mem_rd      = state == S_REQ || (PREFETCH && state == S_HOLD);
    instr_valid = state == S_HOLD;
    mem_addr    = pc;
    opcode      = instr[15:12];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc       <= RESET_PC;
      instr    <= '0;
      instr_pc <= '0;
    end else if (jump) begin
      pc <= jump_addr & MASK;
    end else if (state == S_DATA) begin
      instr    <= mem_rdata;
      instr_pc <= pc;
      pc       <= (pc + 16'd1) & MASK;
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch with a word-level delivery model.
module tb_instr_fetch;
`ifdef FETCH_PREFETCH_EN
  localparam int PF = 1;
`else
  localparam int PF = 0;
`endif
  localparam logic [15:0] MASK = 16'h3FFF;
  typedef struct {logic [15:0] addr; logic [15:0] data;} exp_t;
  typedef struct {logic [15:0] addr; logic [15:0] data; int cyc;} log_t;
  logic clk = 0, reset = 0, run = 0, jump = 0, instr_ready = 0;
  logic [15:0] jump_addr = 0, mem_addr, mem_rdata = 0, instr, instr_pc, pc;
  logic [3:0] opcode;
  logic mem_rd, instr_valid;
  logic [15:0] mem [0:16383];
  exp_t sb[$];
  log_t lg[$];
  int total = 0, bad = 0, hs_count = 0, cyc = 0;
  logic [15:0] mpc = 0;
  logic p_valid = 0, p_hs = 0, p_jump = 0, p_reset = 0;
  logic [15:0] p_instr = 0, p_ipc = 0, p_pc = 0;

  instr_fetch dut (
    .clk(clk), .reset(reset), .run(run), .jump(jump), .jump_addr(jump_addr),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .instr(instr), .opcode(opcode), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) mem_rdata <= mem[mem_addr[13:0]];
  always @(posedge clk) cyc <= cyc + 1;

  // reference: the consumer must see consecutive addresses, restarted by jump or reset
  always begin
    @(negedge clk);
    #1;
    if (!reset) begin
      sb.delete();
      mpc = 16'h0000;
      sb.push_back('{mpc, mem[mpc[13:0]]});
    end else begin
      if (instr_valid && instr_ready) begin
        mpc = (mpc + 16'd1) & MASK;
        sb.push_back('{mpc, mem[mpc[13:0]]});
      end
      if (jump) begin
        sb.delete();
        mpc = jump_addr & MASK;
        sb.push_back('{mpc, mem[mpc[13:0]]});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic hs;
    hs = reset && instr_valid && instr_ready;
    if (hs) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL deliver: got pc=%h instr=%h with nothing expected", instr_pc, instr);
      end else begin
        e = sb.pop_front();
        if (instr !== e.data || instr_pc !== e.addr || opcode !== e.data[15:12]) begin
          bad++;
          $display("FAIL deliver: got pc=%h instr=%h op=%h want pc=%h instr=%h", instr_pc, instr, opcode, e.addr, e.data);
        end
      end
      lg.push_back('{instr_pc, instr, cyc});
      hs_count++;
    end
    if (reset && p_reset && p_valid && !p_hs && !p_jump) begin
      total++;
      if (!(instr_valid === 1'b1 && instr === p_instr && instr_pc === p_ipc && pc === p_pc)) begin
        bad++;
        $display("FAIL hold: got v=%b instr=%h ipc=%h pc=%h want v=1 instr=%h ipc=%h pc=%h", instr_valid, instr, instr_pc, pc, p_instr, p_ipc, p_pc);
      end
    end
    p_valid = instr_valid; p_hs = hs; p_jump = jump; p_reset = reset;
    p_instr = instr; p_ipc = instr_pc; p_pc = pc;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_pc", pc, 0); chk("rst_instr", instr, 0); chk("rst_opcode", opcode, 0);
    chk("rst_ipc", instr_pc, 0); chk("rst_valid", instr_valid, 0);
    chk("rst_mem_rd", mem_rd, 0); chk("rst_mem_addr", mem_addr, 0);
  endtask

  initial begin
    int h0, r0;
    for (int i = 0; i < 16384; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1234; mem[1] = 16'h2222; mem[2] = 16'h3333;
    mem[16'h40] = 16'hABCD; mem[16'h100] = 16'h7E01; mem[16'h3FFF] = 16'h5555;
    tick(); tick();
    chk_reset_vals();
    reset = 1; run = 1; instr_ready = 1;
    repeat (5 - PF) tick();
    reset = 0;
    #1;
    chk_reset_vals();
    tick();
    chk_reset_vals();
    reset = 1;
    tick();
    chk("lat1_mem_rd", mem_rd, 1); chk("lat1_valid", instr_valid, 0);
    tick();
    chk("lat2_valid", instr_valid, 0);
    tick();
    chk("first_valid", instr_valid, 1); chk("first_instr", instr, 16'h1234);
    chk("first_opcode", opcode, 4'h1); chk("first_ipc", instr_pc, 0); chk("first_pc", pc, 1);
    instr_ready = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", instr_valid, 1); chk("bp_instr", instr, 16'h1234);
      chk("bp_ipc", instr_pc, 0); chk("bp_pc", pc, 1);
    end
    h0 = hs_count;
    instr_ready = 1;
    tick();
    instr_ready = 0;
    tick(); tick(); tick();
    chk("bp_one_xfer", hs_count - h0, 1); chk("bp_next_valid", instr_valid, 1);
    chk("bp_next_ipc", instr_pc, 1); chk("bp_next_instr", instr, 16'h2222);
    h0 = hs_count;
    instr_ready = 1;
    tick();
    if (PF == 0) tick();
    jump = 1; jump_addr = 16'h0040;
    tick();
    jump = 0;
    chk("jmp_drop1", instr_valid, 0);
    tick();
    chk("jmp_drop2", instr_valid, 0);
    tick();
    chk("jmp_valid", instr_valid, 1); chk("jmp_instr", instr, 16'hABCD);
    chk("jmp_ipc", instr_pc, 16'h0040); chk("jmp_xfers", hs_count - h0, 1);
    h0 = hs_count;
    jump = 1; jump_addr = 16'h0100;
    tick();
    jump = 0; instr_ready = 0;
    chk("jhs_xfer", hs_count - h0, 1); chk("jhs_valid0", instr_valid, 0);
    tick(); tick();
    chk("jhs_valid", instr_valid, 1); chk("jhs_ipc", instr_pc, 16'h0100);
    chk("jhs_instr", instr, 16'h7E01); chk("jhs_xfer_only", hs_count - h0, 1);
    mem[0] = 16'h6666;
    instr_ready = 1; jump = 1; jump_addr = 16'h3FFF;
    tick();
    jump = 0;
    h0 = hs_count;
    for (int i = 0; i < 40 && hs_count < h0 + 4; i++) tick();
    chk("wrap_count", hs_count >= h0 + 4, 1);
    if (hs_count >= h0 + 4) begin
      chk("wrap_ipc0", lg[h0].addr, 16'h3FFF); chk("wrap_d0", lg[h0].data, 16'h5555);
      chk("wrap_ipc1", lg[h0+1].addr, 16'h0000); chk("wrap_d1", lg[h0+1].data, 16'h6666);
      chk("seq_ipc3", lg[h0+3].addr, 16'h0002);
      for (int i = 1; i < 4; i++) chk("rate", lg[h0+i].cyc - lg[h0+i-1].cyc, 3 - PF);
    end
    r0 = hs_count;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (!reset) reset = 1;
      else if ($urandom_range(599) == 0) reset = 0;
      run = $urandom_range(7) != 0;
      instr_ready = $urandom_range(3) != 0;
      jump = $urandom_range(19) == 0;
      jump_addr = ($urandom_range(3) == 0) ? 16'h3FFF - 16'($urandom_range(2)) : 16'($urandom);
    end
    reset = 1; jump = 0; run = 0; instr_ready = 1;
    repeat (10) tick();
    chk("rand_progress", hs_count - r0 > 100, 1);
    chk("idle_after_stop", instr_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch sequencer for the 16-bit accumulator datapath. It owns the program counter and drives the read address of the synchronous single-port main memory. It captures each returned word into an instruction register and presents it downstream with a valid/ready handshake. Its `opcode` field feeds the ALU operation select, and a jump port lets execute redirect the fetch stream.

## Interface
Parameters:
- `MEM_WORDS`, 16384: memory depth in words; must be a power of 2; PC wraps modulo this.
- `RESET_PC`, 16'h0000: PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; 0 = reset asserted.
- `run`  in  1  fetch enable; level-sensitive.
- `jump`  in  1  redirect request, sampled each rising edge.
- `jump_addr`  in  16  redirect target.
- `mem_addr`  out  16  read address to main memory; the memory `write_enable` is tied low at top level.
- `mem_rd`  out  1  marks the cycle(s) in which `mem_addr` is a live fetch address.
- `mem_rdata`  in  16  memory `data_out`; valid one cycle after the address is sampled.
- `instr`  out  16  instruction register.
- `opcode`  out  4  `instr[15:12]`, to the ALU opcode input.
- `instr_pc`  out  16  address the held `instr` was fetched from.
- `instr_valid`  out  1  `instr` is valid for the consumer.
- `instr_ready`  in  1  consumer accepts `instr` this cycle.
- `pc`  out  16  address of the next fetch.

## Operation
- Registers:
  - `pc`, 16 bits.
  - `instr`, 16 bits.
  - `instr_pc`, 16 bits.
  - `state`, 2 bits.
- `mem_addr` = `pc` combinationally, in every state.
- FSM states: S_IDLE, S_REQ, S_DATA, S_HOLD.
  - S_IDLE: `mem_rd`=0. Moves to S_REQ when `run`=1.
  - S_REQ: `mem_rd`=1; memory samples `pc` at the closing edge. Always moves to S_DATA.
  - S_DATA: `mem_rdata` is valid. At the closing edge:
    - `instr`<=`mem_rdata`
    - `instr_pc`<=`pc`
    - `pc`<=(`pc`+1) & (MEM_WORDS-1)
    - move to S_HOLD.
  - S_HOLD: `instr_valid`=1; `instr`, `instr_pc` and `pc` are held stable.
    - On `instr_valid`&`instr_ready`: go to S_REQ if `run`=1, else S_IDLE.
    - Otherwise stay in S_HOLD.
- `instr_valid` is 1 only in S_HOLD. It never drops without a handshake, except on jump or reset.
- Jump has top priority in every state. It is applied at the edge where `jump`=1:
  - `pc`<=`jump_addr` & (MEM_WORDS-1).
  - Any in-flight read (S_REQ/S_DATA) or held instruction (S_HOLD) is discarded; `instr` is left unchanged, but `instr_valid` falls.
  - Next state is S_REQ if `run`=1, else S_IDLE.
  - In S_IDLE, only `pc` loads.
- Jump and handshake in the same S_HOLD cycle: the transfer counts as accepted and the jump also applies; the consumer sees exactly one accepted instruction.
- `run` falling mid-fetch does not abort the fetch. The current instruction completes through S_HOLD and its handshake, then the FSM goes to S_IDLE.
- PC wrap: `pc`=MEM_WORDS-1 fetches, then `pc` becomes 0. No flag is raised.
- Reset (async, any state): the FSM returns to S_IDLE and any partial fetch is dropped. Output values while reset is asserted:
  - `pc`=RESET_PC
  - `instr`=0, `opcode`=0
  - `instr_pc`=0
  - `instr_valid`=0
  - `mem_rd`=0
  - `mem_addr`=RESET_PC

## Timing
- Latency from `run` rising (sampled in S_IDLE) to `instr_valid`=1 is 3 edges: IDLE→REQ→DATA→HOLD.
- Base throughput is one instruction per 3 cycles with `instr_ready` held at 1.
- After a jump, the first valid instruction from `jump_addr` appears 2 edges after the jump edge.
- `instr_ready` may be asserted before `instr_valid`; it has no effect outside S_HOLD.

## Configuration
- `FETCH_PREFETCH_EN` defined:
  - In S_HOLD, `mem_rd`=1, so memory samples `pc` every cycle.
  - A handshake in S_HOLD (no jump, `run`=1) moves directly to S_DATA, skipping S_REQ.
  - Throughput becomes one instruction per 2 cycles.
  - Jump behaviour is unchanged.
- `FETCH_PREFETCH_EN` undefined: behaviour is exactly as in Operation; `mem_rd`=0 in S_HOLD.

## Test plan
- Reset and first fetch:
  - Stimulus: reset low mid-S_DATA; release; mem[0]=16'h1234; `run`=1, `instr_ready`=1.
  - Response: all outputs at reset values while reset is low. After release, `instr_valid`=1 on the 3rd edge with `instr`=16'h1234, `opcode`=4'h1, `instr_pc`=0, `pc`=1.
- Backpressure:
  - Stimulus: `instr_ready`=0 for 5 cycles in S_HOLD.
  - Response: `instr`, `instr_pc` and `pc` stable, `instr_valid`=1 throughout. After `instr_ready`=1, exactly one transfer, then the next fetch at `pc`=1.
- Jump:
  - Stimulus: `jump`=1, `jump_addr`=16'h0040 in S_DATA; mem[0x40]=16'hABCD.
  - Response: the in-flight word is dropped and never marked valid. `instr`=16'hABCD, `instr_pc`=16'h0040 valid 2 edges later.
- Jump with handshake:
  - Stimulus: `jump` and `instr_valid`&`instr_ready` in the same S_HOLD cycle, `jump_addr`=16'h0100.
  - Response: one transfer counted; the next valid instruction comes from 16'h0100.
- Wrap:
  - Stimulus: `jump_addr`=16'h3FFF (MEM_WORDS=16384); mem[0x3FFF]=16'h5555, mem[0]=16'h6666.
  - Response: the consumer sees 16'h5555 then 16'h6666, with `instr_pc` 16'h3FFF then 16'h0000.
- Prefetch (`FETCH_PREFETCH_EN`):
  - Stimulus: `instr_ready`=1, 4 sequential words.
  - Response: `instr_valid` accepted every 2 cycles, with the same data order as the non-prefetch build.
